// File: rtl/led_matrix_scan.sv
// Row/column scan driver for an LED matrix: double-buffered frame input,
// pixel or row scan with a programmable tick divider and PWM brightness.
module led_matrix_scan #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int DIV_W    = 16,
  parameter int PWM_BITS = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ROWS*COLS-1:0]   frame_in,
  input  logic                   frame_valid,
  output logic                   frame_ready,
  input  logic [DIV_W-1:0]       div,
  input  logic                   mode,
  input  logic [PWM_BITS-1:0]    brightness,
  output logic [ROWS-1:0]        row_out,
  output logic [COLS-1:0]        column_out,
  output logic                   frame_start
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  logic [DIV_W-1:0]     presc_cnt;
  logic [PWM_BITS-1:0]  pwm_cnt;
  logic [ROW_W-1:0]     row_idx;
  logic [COL_W-1:0]     col_idx;
  logic                 mode_act;
  logic                 mode_loaded;
  logic                 boundary_d;
  logic [ROWS*COLS-1:0] display_buf;
  logic [ROWS*COLS-1:0] shadow_buf;
  logic                 shadow_full;

  logic                 tick;
  logic                 slot_end;
  logic                 last_pos;
  logic                 boundary;
  logic                 accept;
  logic                 mode_eff;
  logic                 en;
  logic [COLS-1:0]      disp_rows [ROWS];
  logic [COLS-1:0]      row_bits;
  logic [COLS-1:0]      col_onehot;
  logic [ROWS-1:0]      row_onehot;

  // Until the first clock after reset release the mode pin is used directly.
  assign mode_eff    = mode_loaded ? mode_act : mode;
  assign tick        = (presc_cnt >= div);
  assign slot_end    = tick && (pwm_cnt == '1);
  assign last_pos    = (row_idx == ROW_LAST) && (mode_eff || (col_idx == COL_LAST));
  assign boundary    = slot_end && last_pos;
  assign frame_ready = ~shadow_full;
  assign accept      = frame_valid && ~shadow_full;
  assign en          = (pwm_cnt <= brightness);

  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_rows
      assign disp_rows[gi] = display_buf[gi*COLS +: COLS];
    end
  endgenerate

  assign row_bits   = disp_rows[row_idx];
  assign row_onehot = {{(ROWS-1){1'b0}}, 1'b1} << row_idx;
  assign col_onehot = {{(COLS-1){1'b0}}, 1'b1} << col_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_cnt   <= '0;
      pwm_cnt     <= '0;
      row_idx     <= '0;
      col_idx     <= '0;
      mode_act    <= 1'b0;
      mode_loaded <= 1'b0;
      display_buf <= '0;
      shadow_buf  <= '0;
      shadow_full <= 1'b0;
    end else begin
      presc_cnt   <= tick ? '0 : presc_cnt + 1'b1;
      mode_loaded <= 1'b1;
      if (!mode_loaded || boundary) begin
        mode_act <= mode;
      end
      if (tick) begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
      if (slot_end) begin
        if (mode_eff || (col_idx == COL_LAST)) begin
          col_idx <= '0;
          row_idx <= (row_idx == ROW_LAST) ? '0 : row_idx + 1'b1;
        end else begin
          col_idx <= col_idx + 1'b1;
        end
      end
      // Accept needs an empty shadow, so it can never coincide with a swap.
      if (accept) begin
        shadow_buf  <= frame_in;
        shadow_full <= 1'b1;
      end else if (boundary && shadow_full) begin
        display_buf <= shadow_buf;
        shadow_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_out     <= '0;
      column_out  <= '1;
      frame_start <= 1'b0;
      boundary_d  <= 1'b0;
    end else begin
      boundary_d  <= boundary;
      frame_start <= boundary_d;
      row_out     <= row_onehot;
      if (!en) begin
        column_out <= '1;
      end else if (mode_eff) begin
        column_out <= ~row_bits;
      end else begin
        column_out <= ~(row_bits & col_onehot);
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan: an 8x8 and a 4x6 instance, expected
// outputs per clock queued as stimulus is driven and popped on each sample.
`timescale 1ns/1ps
module tb_led_matrix_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst = 1'b0, a_valid = 1'b0, a_mode = 1'b0;
  logic        a_ready, a_fs;
  logic [63:0] a_frame = '0;
  logic [15:0] a_div = '0;
  logic [2:0]  a_bright = '0;
  logic [7:0]  a_row, a_col;

  logic        b_rst = 1'b0, b_valid = 1'b0, b_mode = 1'b0;
  logic        b_ready, b_fs;
  logic [23:0] b_frame = '0;
  logic [15:0] b_div = '0;
  logic [2:0]  b_bright = '0;
  logic [3:0]  b_row;
  logic [5:0]  b_col;

  led_matrix_scan #(.ROWS(8), .COLS(8), .DIV_W(16), .PWM_BITS(3)) u_a (
    .clk(clk), .reset(a_rst), .frame_in(a_frame), .frame_valid(a_valid),
    .frame_ready(a_ready), .div(a_div), .mode(a_mode), .brightness(a_bright),
    .row_out(a_row), .column_out(a_col), .frame_start(a_fs)
  );

  led_matrix_scan #(.ROWS(4), .COLS(6), .DIV_W(16), .PWM_BITS(3)) u_b (
    .clk(clk), .reset(b_rst), .frame_in(b_frame), .frame_valid(b_valid),
    .frame_ready(b_ready), .div(b_div), .mode(b_mode), .brightness(b_bright),
    .row_out(b_row), .column_out(b_col), .frame_start(b_fs)
  );

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] pack_a(input logic [7:0] r, input logic [7:0] c,
                                         input logic fs, input logic rdy);
    return {14'd0, r, c, fs, rdy};
  endfunction

  function automatic logic [31:0] pack_b(input logic [3:0] r, input logic [5:0] c,
                                         input logic fs, input logic rdy);
    return {20'd0, r, c, fs, rdy};
  endfunction

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag   = tag;
    e.value = v;
    sb.push_back(e);
  endtask

  task automatic check_pop(input logic [31:0] obs);
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (obs === e.value) else begin
      errors++;
      $error("FAIL %s observed={row,col,fs,rdy}=%h expected=%h", e.tag, obs, e.value);
    end
  endtask

  task automatic step_a();
    @(posedge clk); #1;
    check_pop(pack_a(a_row, a_col, a_fs, a_ready));
  endtask

  task automatic step_b();
    @(posedge clk); #1;
    check_pop(pack_b(b_row, b_col, b_fs, b_ready));
  endtask

  // Holds reset, checks reset values, releases just after a posedge so the next edge is edge 1.
  task automatic reset_a(input logic m, input logic [15:0] d, input logic [2:0] br,
                         input logic [63:0] f, input string tag);
    @(posedge clk); #1;
    a_rst = 1'b0; a_mode = m; a_div = d; a_bright = br; a_frame = f; a_valid = 1'b1;
    #1;
    push_exp({tag, " reset"}, pack_a(8'h00, 8'hFF, 1'b0, 1'b1));
    check_pop(pack_a(a_row, a_col, a_fs, a_ready));
    @(posedge clk); #1;
    a_rst = 1'b1;
  endtask

  initial begin
    logic [63:0] fa, fb, ones;
    logic [23:0] fbp;
    logic [7:0]  er, ec;
    logic [3:0]  erb;
    logic [5:0]  ecb, oh;
    logic        efs, erdy;
    int          s, pwm, slot, fr, row, col;

    ones = '1;

    // Pixel scan, only pixel (2,5) lit.
    fa = '0;
    fa[2*8+5] = 1'b1;
    reset_a(1'b0, 16'd0, 3'd7, fa, "pix");
    for (int n = 1; n <= 1100; n++) begin
      s = (n - 1) / 8; slot = s % 64; fr = s / 64; row = slot / 8;
      er   = 8'h01 << row;
      ec   = (fr >= 1 && slot == 21) ? 8'hDF : 8'hFF;
      efs  = (n > 1) && ((n - 1) % 512 == 0);
      erdy = (n >= 512);
      push_exp($sformatf("pix n=%0d", n), pack_a(er, ec, efs, erdy));
      step_a();
      if (n == 1) a_valid = 1'b0;
    end

    // Row scan, all-ones frame, brightness 2.
    reset_a(1'b1, 16'd0, 3'd2, ones, "rowpwm");
    for (int n = 1; n <= 200; n++) begin
      s = (n - 1) / 8; pwm = (n - 1) % 8; row = s % 8; fr = (n - 1) / 64;
      er   = 8'h01 << row;
      ec   = (fr >= 1 && pwm <= 2) ? 8'h00 : 8'hFF;
      efs  = (n > 1) && ((n - 1) % 64 == 0);
      erdy = (n >= 64);
      push_exp($sformatf("rowpwm n=%0d", n), pack_a(er, ec, efs, erdy));
      step_a();
      if (n == 1) a_valid = 1'b0;
    end

    // Handshake: A accepted at once, B held valid until the boundary frees the shadow.
    for (int r = 0; r < 8; r++) begin
      fa[r*8 +: 8] = 8'hA5 ^ 8'(r * 17);
      fb[r*8 +: 8] = 8'h3C + 8'(r * 3);
    end
    reset_a(1'b1, 16'd0, 3'd7, fa, "hs");
    for (int n = 1; n <= 200; n++) begin
      row = ((n - 1) / 8) % 8; fr = (n - 1) / 64;
      er   = 8'h01 << row;
      ec   = (fr == 0) ? 8'hFF : (fr == 1) ? ~fa[row*8 +: 8] : ~fb[row*8 +: 8];
      efs  = (n > 1) && ((n - 1) % 64 == 0);
      erdy = (n == 64) || (n >= 128);
      push_exp($sformatf("hs n=%0d", n), pack_a(er, ec, efs, erdy));
      step_a();
      if (n == 1)  a_frame = fb;
      if (n == 65) a_valid = 1'b0;
    end

    // Mode switch pixel->row mid-frame takes effect only at the boundary.
    reset_a(1'b0, 16'd0, 3'd7, ones, "modesw");
    for (int n = 1; n <= 700; n++) begin
      if (n <= 512) begin
        row = (((n - 1) / 8) / 8) % 8;
        ec  = 8'hFF;
      end else begin
        row = ((n - 513) / 8) % 8;
        ec  = 8'h00;
      end
      er   = 8'h01 << row;
      efs  = (n == 513) || (n > 513 && (n - 513) % 64 == 0);
      erdy = (n >= 512);
      push_exp($sformatf("modesw n=%0d", n), pack_a(er, ec, efs, erdy));
      step_a();
      if (n == 1)   a_valid = 1'b0;
      if (n == 100) a_mode = 1'b1;
    end

    // div=3: tick every 4 clk, 32-clk row slots.
    reset_a(1'b1, 16'd3, 3'd7, '0, "div3");
    for (int n = 1; n <= 300; n++) begin
      row  = ((n - 1) / 32) % 8;
      er   = 8'h01 << row;
      efs  = (n == 257);
      erdy = (n >= 256);
      push_exp($sformatf("div3 n=%0d", n), pack_a(er, 8'hFF, efs, erdy));
      step_a();
      if (n == 1) a_valid = 1'b0;
    end

    // div 9 -> 2 while the prescaler sits at 7: tick on the very next clock.
    reset_a(1'b1, 16'd9, 3'd7, '0, "divchg");
    for (int n = 1; n <= 60; n++) begin
      row  = (n <= 29) ? 0 : 1 + (n - 30) / 24;
      er   = 8'h01 << row;
      push_exp($sformatf("divchg n=%0d", n), pack_a(er, 8'hFF, 1'b0, 1'b0));
      step_a();
      if (n == 1) a_valid = 1'b0;
      if (n == 7) a_div = 16'd2;
    end
    a_rst = 1'b0;

    // 4x6 pixel scan with an irregular bitmap, then an asynchronous reset mid-frame.
    fbp = 24'hB53C96;
    @(posedge clk); #1;
    b_mode = 1'b0; b_div = 16'd0; b_bright = 3'd7; b_frame = fbp; b_valid = 1'b1;
    #1;
    push_exp("b reset", pack_b(4'h0, 6'h3F, 1'b0, 1'b1));
    check_pop(pack_b(b_row, b_col, b_fs, b_ready));
    @(posedge clk); #1;
    b_rst = 1'b1;
    for (int n = 1; n <= 402; n++) begin
      s = (n - 1) / 8; slot = s % 24; fr = s / 24; row = slot / 6; col = slot % 6;
      erb  = 4'h1 << row;
      oh   = 6'h01 << col;
      ecb  = (fr >= 1 && fbp[slot]) ? ~oh : 6'h3F;
      efs  = (n > 1) && ((n - 1) % 192 == 0);
      erdy = (n >= 192) && (n < 401);
      push_exp($sformatf("b4x6 n=%0d", n), pack_b(erb, ecb, efs, erdy));
      step_b();
      if (n == 1)   b_valid = 1'b0;
      if (n == 400) begin b_frame = 24'hFFFFFF; b_valid = 1'b1; end
      if (n == 401) b_valid = 1'b0;
    end
    #2;
    b_rst = 1'b0;
    #1;
    push_exp("b midreset", pack_b(4'h0, 6'h3F, 1'b0, 1'b1));
    check_pop(pack_b(b_row, b_col, b_fs, b_ready));
    @(posedge clk); #1;
    b_rst = 1'b1;
    for (int n = 1; n <= 250; n++) begin
      s = (n - 1) / 8; slot = s % 24; row = slot / 6;
      erb  = 4'h1 << row;
      efs  = (n > 1) && ((n - 1) % 192 == 0);
      push_exp($sformatf("b after reset n=%0d", n), pack_b(erb, 6'h3F, efs, 1'b1));
      step_b();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
